// File: rtl/axis_packet_tx.sv
// FIFO-buffered AXI4-Stream packet transmitter. Message words enter on a valid/ready push port.
// Packets are split at MAX_BEATS beats, and an optional store-and-forward mode holds output until a whole packet is buffered.
module axis_packet_tx #(
   parameter int DATA_WIDTH  = 64,
   parameter int ID_WIDTH    = 8,
   parameter int DEST_WIDTH  = 4,
   parameter int DEPTH       = 8,
   parameter int MAX_BEATS   = 17,
   parameter int PACKET_MODE = 0
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [$clog2(DATA_WIDTH/8):0] in_bytes,
   input  logic                          in_last,
   input  logic [ID_WIDTH-1:0]           cfg_id,
   input  logic [DEST_WIDTH-1:0]         cfg_dest,
   input  logic                          TREADY,
   output logic                          TVALID,
   output logic [DATA_WIDTH-1:0]         TDATA,
   output logic [DATA_WIDTH/8-1:0]       TKEEP,
   output logic [DATA_WIDTH/8-1:0]       TSTRB,
   output logic                          TLAST,
   output logic [ID_WIDTH-1:0]           TID,
   output logic [DEST_WIDTH-1:0]         TDEST,
   output logic [$clog2(DATA_WIDTH/8):0] TUSER,
   output logic [$clog2(DEPTH):0]        fifo_level,
   output logic [15:0]                   pkt_count
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BW    = $clog2(BYTES) + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam int BCW   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [BYTES-1:0]      keep;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
      logic [DEST_WIDTH-1:0] dest;
      logic [BW-1:0]         user;
   } entry_t;

   typedef enum logic {IDLE, SEND} state_t;

   entry_t                mem [DEPTH];
   entry_t                wr_entry, rd_entry;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         count, count_nxt;
   logic [LW-1:0]         pkts_in_fifo, pkts_nxt;
   logic [BCW-1:0]        beat_cnt;
   logic [ID_WIDTH-1:0]   id_q;
   logic [DEST_WIDTH-1:0] dest_q;
   logic [BW-1:0]         n_bytes;
   logic                  init_done;
   logic                  full, empty, push, pop, push_last, pop_last, first_beat, tvalid_int;
   state_t                state, state_d;

   assign full       = (count == LW'(DEPTH));
   assign empty      = (count == '0);
   assign in_ready   = init_done && !full;
   assign push       = in_valid && in_ready;
   assign tvalid_int = (state == SEND) && !empty;
   assign pop        = tvalid_int && TREADY;
   assign rd_entry   = mem[rd_ptr];
   assign push_last  = push && wr_entry.last;
   assign pop_last   = pop && rd_entry.last;
   assign first_beat = (beat_cnt == '0);

   // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      n_bytes = in_bytes;
      if (in_bytes == '0 || in_bytes > BW'(BYTES)) n_bytes = BW'(BYTES);
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = in_data;
      for (int i = 0; i < BYTES; i++) wr_entry.keep[i] = (BW'(i) < n_bytes);
      // A full rate block closes the packet even without in_last.
      wr_entry.last = in_last || (beat_cnt == BCW'(MAX_BEATS - 1));
      wr_entry.id   = first_beat ? cfg_id   : id_q;
      wr_entry.dest = first_beat ? cfg_dest : dest_q;
      wr_entry.user = n_bytes;
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + LW'(1);
      else if (!push && pop) count_nxt = count - LW'(1);
      pkts_nxt = pkts_in_fifo;
      if (push_last && !pop_last)      pkts_nxt = pkts_in_fifo + LW'(1);
      else if (!push_last && pop_last) pkts_nxt = pkts_in_fifo - LW'(1);
   end

   // IDLE looks at post-edge occupancy so the first beat is presented without an extra cycle.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (count_nxt != '0 &&
                   (PACKET_MODE == 0 || pkts_nxt != '0 || count_nxt == LW'(DEPTH)))
                  state_d = SEND;
         SEND: if (pop_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the storage array has no reset; pointers and counters alone define what is valid.
   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         pkts_in_fifo <= '0;
         beat_cnt     <= '0;
         id_q         <= '0;
         dest_q       <= '0;
         pkt_count    <= '0;
         init_done    <= 1'b0;
      end else begin
         state        <= state_d;
         count        <= count_nxt;
         pkts_in_fifo <= pkts_nxt;
         init_done    <= 1'b1;
         if (push) begin
            wr_ptr   <= wr_ptr + AW'(1);
            beat_cnt <= wr_entry.last ? '0 : beat_cnt + BCW'(1);
            if (first_beat) begin
               id_q   <= cfg_id;
               dest_q <= cfg_dest;
            end
         end
         if (pop)      rd_ptr    <= rd_ptr + AW'(1);
         if (pop_last) pkt_count <= pkt_count + 16'd1;
      end
   end

   assign TVALID     = tvalid_int;
   assign TDATA      = tvalid_int ? rd_entry.data : '0;
   assign TKEEP      = tvalid_int ? rd_entry.keep : '0;
   assign TSTRB      = TKEEP;
   assign TLAST      = tvalid_int && rd_entry.last;
   assign TID        = tvalid_int ? rd_entry.id   : '0;
   assign TDEST      = tvalid_int ? rd_entry.dest : '0;
   assign TUSER      = tvalid_int ? rd_entry.user : '0;
   assign fifo_level = count;

endmodule

// File: tb/tb_axis_packet_tx.sv
// Directed bench for axis_packet_tx: one cut-through and one store-and-forward instance,
// with a shared stimulus and a sel-controlled output mux.
module tb_axis_packet_tx;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        sel;
   logic        in_valid, in_last, TREADY;
   logic [63:0] in_data;
   logic [3:0]  in_bytes;
   logic [7:0]  cfg_id;
   logic [3:0]  cfg_dest;

   logic        c_in_ready, c_tvalid, c_tlast, s_in_ready, s_tvalid, s_tlast;
   logic [63:0] c_tdata, s_tdata;
   logic [7:0]  c_tkeep, c_tstrb, c_tid, s_tkeep, s_tstrb, s_tid;
   logic [3:0]  c_tdest, c_tuser, c_level, s_tdest, s_tuser, s_level;
   logic [15:0] c_pkt, s_pkt;

   logic        in_ready, tvalid, tlast;
   logic [63:0] tdata;
   logic [7:0]  tkeep, tstrb, tid;
   logic [3:0]  tdest, tuser, level;
   logic [15:0] pkt;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic [7:0]  strb;
      logic        last;
      logic [7:0]  id;
      logic [3:0]  dest;
      logic [3:0]  user;
      logic [3:0]  lvl;
   } beat_t;

   beat_t cap[$];
   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   always #5 ACLK = ~ACLK;

   axis_packet_tx #(.PACKET_MODE(0)) dut_ct (
      .ACLK(ACLK), .ARESET(ARESET), .in_valid(in_valid && !sel), .in_ready(c_in_ready),
      .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last), .cfg_id(cfg_id),
      .cfg_dest(cfg_dest), .TREADY(TREADY), .TVALID(c_tvalid), .TDATA(c_tdata),
      .TKEEP(c_tkeep), .TSTRB(c_tstrb), .TLAST(c_tlast), .TID(c_tid), .TDEST(c_tdest),
      .TUSER(c_tuser), .fifo_level(c_level), .pkt_count(c_pkt));

   axis_packet_tx #(.PACKET_MODE(1)) dut_sf (
      .ACLK(ACLK), .ARESET(ARESET), .in_valid(in_valid && sel), .in_ready(s_in_ready),
      .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last), .cfg_id(cfg_id),
      .cfg_dest(cfg_dest), .TREADY(TREADY), .TVALID(s_tvalid), .TDATA(s_tdata),
      .TKEEP(s_tkeep), .TSTRB(s_tstrb), .TLAST(s_tlast), .TID(s_tid), .TDEST(s_tdest),
      .TUSER(s_tuser), .fifo_level(s_level), .pkt_count(s_pkt));

   assign in_ready = sel ? s_in_ready : c_in_ready;
   assign tvalid   = sel ? s_tvalid   : c_tvalid;
   assign tlast    = sel ? s_tlast    : c_tlast;
   assign tdata    = sel ? s_tdata    : c_tdata;
   assign tkeep    = sel ? s_tkeep    : c_tkeep;
   assign tstrb    = sel ? s_tstrb    : c_tstrb;
   assign tid      = sel ? s_tid      : c_tid;
   assign tdest    = sel ? s_tdest    : c_tdest;
   assign tuser    = sel ? s_tuser    : c_tuser;
   assign level    = sel ? s_level    : c_level;
   assign pkt      = sel ? s_pkt      : c_pkt;

   // Inputs change 1 time unit after posedge, so at negedge this sees the handshake about to happen.
   always @(negedge ACLK) begin
      if (ARESET === 1'b0 && tvalid && TREADY)
         cap.push_back('{tdata, tkeep, tstrb, tlast, tid, tdest, tuser, level});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] kmask(input int nb);
      int         m;
      logic [8:0] t;
      m = (nb == 0 || nb > 8) ? 8 : nb;
      t = (9'd1 << m) - 9'd1;
      return t[7:0];
   endfunction

   function automatic void add_exp(input logic [63:0] d, input int nb, input logic last,
                                   input logic [7:0] id, input logic [3:0] dest);
      beat_t b;
      int    m;
      m      = (nb == 0 || nb > 8) ? 8 : nb;
      b.data = d;
      b.keep = kmask(m);
      b.strb = kmask(m);
      b.last = last;
      b.id   = id;
      b.dest = dest;
      b.user = 4'(m);
      b.lvl  = 4'd0;
      exp_q.push_back(b);
   endfunction

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push(input logic [63:0] d, input int nb, input logic last);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      in_bytes = 4'(nb);
      in_last  = last;
      t        = 0;
      @(negedge ACLK);
      while (!in_ready && t < 200) begin
         @(negedge ACLK);
         t++;
      end
      if (t >= 200) check("push_timeout", 64'(t), 64'd0);
      step();
      in_valid = 1'b0;
   endtask

   task automatic verify(input string tag);
      int t;
      t = 0;
      while (cap.size() < exp_q.size() && t < 300) begin
         @(negedge ACLK);
         t++;
      end
      repeat (4) @(negedge ACLK);
      check({tag, "_count"}, 64'(cap.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), cap[i].data, exp_q[i].data);
         check($sformatf("%s_qual%0d", tag, i), 64'({cap[i].strb, cap[i].keep, cap[i].user}),
               64'({exp_q[i].strb, exp_q[i].keep, exp_q[i].user}));
         check($sformatf("%s_ctrl%0d", tag, i), 64'({cap[i].last, cap[i].id, cap[i].dest}),
               64'({exp_q[i].last, exp_q[i].id, exp_q[i].dest}));
      end
      cap.delete();
      exp_q.delete();
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] td [3];
      int          tn [3];
      int          lvl;

      ARESET = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0; in_bytes = '0;
      in_last = 1'b0; cfg_id = '0; cfg_dest = '0; TREADY = 1'b0;

      // Reset state
      step(); step();
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_payload", tdata | 64'({tkeep, tstrb, tlast, tid, tdest, tuser}), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_pkt", 64'(pkt), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      step();
      @(negedge ACLK);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      step();

      // Cut-through stream: 8, 8, 3 bytes
      td[0] = 64'hA1A1_0000_0000_0001; td[1] = 64'hA2A2_0000_0000_0002; td[2] = 64'h0000_0000_00C3_B2A1;
      tn[0] = 8; tn[1] = 8; tn[2] = 3;
      cfg_id = 8'h11; cfg_dest = 4'h3; TREADY = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            in_valid = 1'b1; in_data = td[c]; in_bytes = 4'(tn[c]); in_last = (c == 2);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge ACLK);
         check($sformatf("ct_tvalid%0d", c), 64'(tvalid), 64'((c >= 1 && c <= 3)));
         if (c >= 1 && c <= 3) begin
            check($sformatf("ct_data%0d", c), tdata, td[c-1]);
            check($sformatf("ct_qual%0d", c), 64'({tlast, tkeep, tuser, tid}),
                  64'({(c == 3), kmask(tn[c-1]), 4'(tn[c-1]), 8'h11}));
         end else begin
            check($sformatf("ct_masked%0d", c), tdata, 64'd0);
         end
         step();
      end
      @(negedge ACLK);
      check("ct_pkt", 64'(pkt), 64'd1);
      step();
      cap.delete();

      // Forced split at 17 beats, cfg changes from beat 10
      cfg_id = 8'h5A; cfg_dest = 4'h3;
      for (int i = 1; i <= 20; i++) begin
         if (i == 10) begin
            cfg_id = 8'hA5; cfg_dest = 4'hA;
         end
         push(64'h100 + 64'(i), i % 10, (i == 20));
         add_exp(64'h100 + 64'(i), i % 10, (i == 17 || i == 20),
                 (i <= 17) ? 8'h5A : 8'hA5, (i <= 17) ? 4'h3 : 4'hA);
      end
      verify("split");
      @(negedge ACLK);
      check("split_pkt", 64'(pkt), 64'd3);
      step();

      // Backpressure: TREADY low for 12 cycles while pushing
      TREADY = 1'b0; cfg_id = 8'h33; cfg_dest = 4'h3; lvl = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1; in_data = 64'h300 + 64'(lvl); in_bytes = 4'd8; in_last = 1'b0;
         @(negedge ACLK);
         check($sformatf("bp_level%0d", c), 64'(level), 64'(lvl));
         check($sformatf("bp_ready%0d", c), 64'(in_ready), 64'((lvl < 8)));
         check($sformatf("bp_tvalid%0d", c), 64'(tvalid), 64'((lvl > 0)));
         if (lvl > 0) check($sformatf("bp_hold%0d", c), tdata, 64'h300);
         if (lvl < 8) lvl++;
         step();
      end
      in_valid = 1'b0; TREADY = 1'b1;
      push(64'h308, 8, 1'b0);
      push(64'h309, 5, 1'b1);
      for (int i = 0; i < 10; i++) add_exp(64'h300 + 64'(i), (i == 9) ? 5 : 8, (i == 9), 8'h33, 4'h3);
      verify("bp");
      @(negedge ACLK);
      check("bp_pkt", 64'(pkt), 64'd4);
      step();

      // Store-and-forward, 4 beats with idle gaps
      sel = 1'b1; cfg_id = 8'h44; cfg_dest = 4'h5;
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1; in_data = 64'h400 + 64'(b); in_bytes = 4'(b + 1); in_last = (b == 3);
         add_exp(64'h400 + 64'(b), b + 1, (b == 3), 8'h44, 4'h5);
         @(negedge ACLK);
         check($sformatf("sf_hold%0d", b), 64'(tvalid), 64'd0);
         step();
         in_valid = 1'b0;
         @(negedge ACLK);
         check($sformatf("sf_gap%0d", b), 64'(tvalid), 64'((b == 3)));
         step();
      end
      for (int k = 1; k < 4; k++) begin
         @(negedge ACLK);
         check($sformatf("sf_burst%0d", k), 64'({tvalid, tlast}), 64'({1'b1, (k == 3)}));
         check($sformatf("sf_burst_data%0d", k), tdata, 64'h400 + 64'(k));
         step();
      end
      @(negedge ACLK);
      check("sf_end_tvalid", 64'(tvalid), 64'd0);
      step();
      verify("sf");
      @(negedge ACLK);
      check("sf_pkt", 64'(pkt), 64'd1);
      step();

      // Store-and-forward overflow: 17 beats into an 8-entry FIFO
      cfg_id = 8'h55; cfg_dest = 4'h6;
      for (int i = 0; i < 17; i++) begin
         push(64'h500 + 64'(i), (i % 8) + 1, (i == 16));
         add_exp(64'h500 + 64'(i), (i % 8) + 1, (i == 16), 8'h55, 4'h6);
      end
      repeat (30) @(negedge ACLK);
      check("ovf_start_level", (cap.size() > 0) ? 64'(cap[0].lvl) : 64'hDEAD, 64'd8);
      step();
      verify("ovf");
      @(negedge ACLK);
      check("ovf_pkt", 64'(pkt), 64'd2);
      step();

      // Reset mid-packet
      sel = 1'b0; TREADY = 1'b0; cfg_id = 8'h66; cfg_dest = 4'h7;
      for (int i = 0; i < 5; i++) push(64'h600 + 64'(i), 8, 1'b0);
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      @(negedge ACLK);
      check("mid_rst_tvalid", 64'(tvalid), 64'd0);
      check("mid_rst_level", 64'(level), 64'd0);
      check("mid_rst_pkt", 64'(pkt), 64'd0);
      step();
      TREADY = 1'b1; cfg_id = 8'h77; cfg_dest = 4'h8;
      push(64'h700, 8, 1'b0);
      cfg_id = 8'h78; cfg_dest = 4'h9;
      push(64'h701, 2, 1'b1);
      add_exp(64'h700, 8, 1'b0, 8'h77, 4'h8);
      add_exp(64'h701, 2, 1'b1, 8'h77, 4'h8);
      verify("mid_rst");
      @(negedge ACLK);
      check("mid_rst_pkt_after", 64'(pkt), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_packet_tx.md
# axis_packet_tx

Parametrised, FIFO-buffered AXI-Stream packet transmitter for the SHA3 datapath. It accepts message words from the padding/absorb logic on a simple valid/ready push port and emits a fully compliant AXI4-Stream master. TKEEP/TSTRB/TUSER are derived from a per-beat byte count. Packets longer than `MAX_BEATS` are split automatically so every packet maps onto one Keccak rate block. An optional store-and-forward mode holds output until a whole packet is buffered.

## Interface
Parameters:
- `DATA_WIDTH`, 64: TDATA width; multiple of 8, ≥ 8. `BYTES = DATA_WIDTH/8`. `BW = $clog2(BYTES)+1`.
- `ID_WIDTH`, 8: TID width.
- `DEST_WIDTH`, 4: TDEST width.
- `DEPTH`, 8: FIFO entries; power of 2, ≥ 2.
- `MAX_BEATS`, 17: maximum beats per packet (1088-bit rate at 64 bits); ≥ 1.
- `PACKET_MODE`, 0: 0 = cut-through, 1 = store-and-forward.

Ports:
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESET`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_WIDTH  beat data.
- `in_bytes`  in  BW  valid bytes in the beat, 1..BYTES; 0 or values above BYTES mean BYTES.
- `in_last`  in  1  last beat of a message.
- `cfg_id`  in  ID_WIDTH  TID for the packet; sampled on the packet's first accepted beat.
- `cfg_dest`  in  DEST_WIDTH  TDEST for the packet; sampled on the packet's first accepted beat.
- `TREADY`  in  1  sink ready.
- `TVALID`  out  1  master valid.
- `TDATA`  out  DATA_WIDTH  data.
- `TKEEP`  out  BYTES  byte qualifier.
- `TSTRB`  out  BYTES  byte qualifier; always equal to TKEEP.
- `TLAST`  out  1  packet boundary.
- `TID`  out  ID_WIDTH  stream ID.
- `TDEST`  out  DEST_WIDTH  routing.
- `TUSER`  out  BW  byte count of the beat, after clamping.
- `fifo_level`  out  $clog2(DEPTH)+1  occupied entries.
- `pkt_count`  out  16  packets sent; wraps 0xFFFF→0.

## Operation
- **FIFO entry:** {data, keep, last, id, dest, user}.
- **Input acceptance:** `in_ready = !full`. It is registered state only and never depends on `TREADY`.
- **TKEEP generation:** `TKEEP[i] = (i < n)`, where `n` is the clamped byte count. The low byte lanes are valid. Applies on every beat.
- **Beat counter** (input side, 0..MAX_BEATS-1):
  - Increments on each accepted beat.
  - Clears on a beat stored with last=1.
  - Stored last = `in_last || (beat_cnt == MAX_BEATS-1)`. This is a forced split; the following beat starts a new packet and re-samples `cfg_id`/`cfg_dest`.
- **pkts_in_fifo counter:** +1 on a push with last=1, −1 on a pop with last=1. Both events in the same cycle leave it unchanged.
- **Output FSM, state IDLE:**
  - TVALID=0.
  - Go to SEND when the FIFO is not empty and any of these holds: `PACKET_MODE==0`; `pkts_in_fifo>0`; FIFO full.
  - The FIFO-full condition prevents deadlock when `MAX_BEATS>DEPTH`.
- **Output FSM, state SEND:**
  - TVALID = !empty.
  - Pop on `TVALID && TREADY`.
  - After a TLAST handshake, return to IDLE. SEND is re-entered the next cycle if the IDLE condition holds.
  - In packet mode, TVALID may drop between beats of an overflow packet. It never drops while waiting for TREADY.
- **AXI rule:** once TVALID=1, the payload and TVALID stay stable until the handshake.
- **Payload masking:** TDATA, TKEEP, TSTRB, TLAST, TID, TDEST and TUSER are forced to 0 whenever TVALID=0.
- **pkt_count:** increments on every `TVALID && TREADY && TLAST`.

## Timing
- **Reset:**
  - TVALID=0 and all payload outputs 0.
  - `in_ready=0` during the reset cycle and 1 the cycle after.
  - `fifo_level=0`, `pkt_count=0`, FSM in IDLE, beat counter 0.
- **Reset mid-packet:** FIFO contents are discarded with no TLAST emitted, and counters are cleared.
- **Cut-through latency:** a beat accepted at edge N gives TVALID=1 in cycle N+1 (FSM IDLE→SEND adds no cycle for the first beat). Throughput is 1 beat/cycle with TREADY held high.
- **Store-and-forward latency:** TVALID rises the cycle after the edge that writes the last beat.
- **Simultaneous push and pop:** allowed at any level below full. `fifo_level` is unchanged.
- **FIFO full:** `in_ready=0`. A pop that cycle frees space for the next cycle only.
- **Wrap-around:** pointers wrap modulo DEPTH. `fifo_level` reaches DEPTH exactly when full.
- **Empty:** TVALID=0 in the same cycle the count reaches 0.

## Test plan
- **Cut-through stream:** `PACKET_MODE=0`, DATA_WIDTH=64, TREADY=1, 3 beats with `in_bytes`=8,8,3 and `in_last` on beat 3 → TVALID from cycle N+1; beat 3 has TKEEP=0x07, TUSER=3, TLAST=1; `pkt_count`=1.
- **Forced split:** MAX_BEATS=17, 20 beats, `in_last` only on beat 20, `cfg_id`=0x5A then 0xA5 from beat 10 → TLAST on beats 17 and 20; beats 1–17 carry TID=0x5A, beats 18–20 carry TID=0xA5; `pkt_count`=2.
- **Backpressure:** `PACKET_MODE=0`, TREADY=0 for 12 cycles while pushing, DEPTH=8 → `in_ready`=0 once `fifo_level`=8; TDATA/TVALID stable throughout; no beat lost or duplicated after TREADY=1.
- **Store-and-forward:** `PACKET_MODE=1`, 4-beat packet with one idle cycle between beats → TVALID stays 0 until the cycle after beat 4 is written, then 4 back-to-back beats.
- **Store-and-forward overflow:** `PACKET_MODE=1`, DEPTH=8, 17-beat packet → FIFO fills, output starts at full, all 17 beats delivered in order with TLAST on beat 17.
- **Reset mid-packet:** ARESET high for 1 cycle after 5 of 17 beats → next cycle TVALID=0, `fifo_level`=0, `pkt_count`=0; a new 2-beat packet is emitted intact with TLAST on beat 2.
